// File: rtl/mbo53_pkg.sv
// Shared types and constants for the MBO-5.3 Ethernet PHY management block.
package mbo53_pkg;

  localparam int unsigned PRE_BITS  = 32;
  localparam int unsigned HDR_BITS  = 14;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] ST    = 2'b01;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;

  typedef enum logic [2:0] {
    FR_IDLE,
    FR_PRE,
    FR_HDR,
    FR_TA,
    FR_DATA
  } frame_state_e;

  typedef enum logic [1:0] {
    SQ_PWRUP,
    SQ_BUSY,
    SQ_GAP,
    SQ_DONE
  } seq_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_req_t;

  // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA.
  function automatic logic [31:0] frame_tail(input logic [4:0] phyad, input mdio_req_t req);
    logic [1:0] ta;
    ta = (req.op == OP_WR) ? 2'b10 : 2'b00;
    return {ST, req.op, phyad, req.regad, ta, req.wdata};
  endfunction

endpackage

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: MDC divider, frame shifter and frame FSM.
module mdio_master
  import mbo53_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'h1F,
  parameter int unsigned MDC_DIV  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  mdio_req_t   i_req,
  input  logic        i_mdio,
  output logic        o_mdc,
  output logic        o_mdio_o,
  output logic        o_mdio_oe,
  output logic        o_busy,
  output logic [15:0] o_rdata,
  output logic        o_done
);

  localparam int unsigned DIV_W = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int unsigned BIT_W = 5;

  logic [DIV_W-1:0] r_div;
  logic             r_mdc;
  logic             w_tick;
  logic             w_fall;
  logic             w_rise;

  frame_state_e     r_state, w_state_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  logic [31:0]      r_shift, w_shift_nxt;
  logic             r_mdo, w_mdo_nxt;
  logic             r_mdoe, w_mdoe_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_busy, w_busy_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [15:0]      r_rdata, w_rdata_nxt;
  logic             w_wr;

  assign w_tick = (r_div == DIV_W'(MDC_DIV - 1));
  assign w_fall = w_tick & r_mdc;
  assign w_rise = w_tick & ~r_mdc;
  assign w_wr   = (r_op == OP_WR);

  // Free-running MDC divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (w_tick) begin
      r_div <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FR_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_mdo   <= 1'b1;
      r_mdoe  <= 1'b0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_op    <= OP_WR;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_mdo   <= w_mdo_nxt;
      r_mdoe  <= w_mdoe_nxt;
      r_done  <= w_done_nxt;
      r_pend  <= w_pend_nxt;
      r_busy  <= w_busy_nxt;
      r_op    <= w_op_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Bus data/enable move on MDC falls; read data is captured on MDC rises.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_mdo_nxt   = r_mdo;
    w_mdoe_nxt  = r_mdoe;
    w_done_nxt  = 1'b0;
    w_pend_nxt  = r_pend;
    w_busy_nxt  = r_busy;
    w_op_nxt    = r_op;
    w_rdata_nxt = r_rdata;

    if (i_start && !r_pend && (r_state == FR_IDLE)) begin
      w_pend_nxt  = 1'b1;
      w_busy_nxt  = 1'b1;
      w_op_nxt    = i_req.op;
      w_shift_nxt = frame_tail(PHY_ADDR, i_req);
    end

    if (w_rise && (r_state == FR_DATA) && !w_wr) begin
      w_rdata_nxt = {r_rdata[14:0], i_mdio};
    end

    if (w_fall) begin
      case (r_state)
        FR_IDLE: begin
          if (r_pend) begin
            w_state_nxt = FR_PRE;
            w_bit_nxt   = '0;
            w_mdo_nxt   = 1'b1;
            w_mdoe_nxt  = 1'b1;
            w_pend_nxt  = 1'b0;
          end
        end
        FR_PRE: begin
          if (r_bit == BIT_W'(PRE_BITS - 1)) begin
            w_state_nxt = FR_HDR;
            w_bit_nxt   = '0;
            w_mdo_nxt   = r_shift[31];
            w_shift_nxt = {r_shift[30:0], 1'b0};
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
            w_mdo_nxt = 1'b1;
          end
        end
        FR_HDR, FR_TA: begin
          w_mdo_nxt   = r_shift[31];
          w_shift_nxt = {r_shift[30:0], 1'b0};
          if ((r_state == FR_HDR) && (r_bit == BIT_W'(HDR_BITS - 1))) begin
            w_state_nxt = FR_TA;
            w_bit_nxt   = '0;
            w_mdoe_nxt  = w_wr;
          end else if ((r_state == FR_TA) && (r_bit == BIT_W'(TA_BITS - 1))) begin
            w_state_nxt = FR_DATA;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
        FR_DATA: begin
          if (r_bit == BIT_W'(DATA_BITS - 1)) begin
            w_state_nxt = FR_IDLE;
            w_bit_nxt   = '0;
            w_mdo_nxt   = 1'b1;
            w_mdoe_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_mdo_nxt   = r_shift[31];
            w_shift_nxt = {r_shift[30:0], 1'b0};
          end
        end
        default: w_state_nxt = FR_IDLE;
      endcase
    end
  end

  assign o_mdc     = r_mdc;
  assign o_mdio_o  = r_mdo;
  assign o_mdio_oe = r_mdoe;
  assign o_busy    = r_busy;
  assign o_rdata   = r_rdata;
  assign o_done    = r_done;

endmodule

// File: rtl/mbo_53_top.sv
// MBO-5.3 Ethernet port top: BMCR write then BMSR read(s) over MDIO, MII TX tied idle.
// Define MBO53_MDIO_POLL_EN to keep re-reading BMSR forever instead of stopping after one read.
module mbo_53_top
  import mbo53_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR  = 5'h1F,
  parameter int unsigned MDC_DIV   = 10,
  parameter int unsigned PWRUP_CYC = 16,
  parameter int unsigned GAP_CYC   = 64,
  parameter logic [15:0] BMCR_VAL  = 16'h3100
) (
  input  logic       clk,
  input  logic       BTN_WEST,
  output logic [3:0] e_tx_d,
  output logic       e_tx_en,
  output logic       e_tx_er,
  input  logic       e_tx_clk,
  input  logic [3:0] e_rx_d,
  input  logic       e_rx_er,
  input  logic       e_rx_dv,
  input  logic       e_rx_clk,
  input  logic       e_crc,
  input  logic       e_col,
  output logic       e_mdc,
  inout  wire        e_mdio
);

  localparam int unsigned CNT_MAX = (PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic             w_rst_n;
  logic             w_mdio_o;
  logic             w_mdio_oe;
  logic             w_busy;
  logic             w_done;
  logic [15:0]      w_rdata;
  logic             w_unused_inputs;

  seq_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_start, w_start_nxt;
  mdio_req_t        r_req, w_req_nxt;
  logic [15:0]      r_status, w_status_nxt;

  assign w_rst_n = BTN_WEST;

  // MII transmit path stays idle; receive-side pins are not used yet.
  assign e_tx_d  = 4'h0;
  assign e_tx_en = 1'b0;
  assign e_tx_er = 1'b0;
  assign w_unused_inputs = &{1'b0, e_tx_clk, e_rx_d, e_rx_er, e_rx_dv, e_rx_clk, e_crc, e_col};

  assign e_mdio = w_mdio_oe ? w_mdio_o : 1'bz;

  mdio_master #(
    .PHY_ADDR (PHY_ADDR),
    .MDC_DIV  (MDC_DIV)
  ) u_mdio (
    .clk       (clk),
    .rst_n     (w_rst_n),
    .i_start   (r_start),
    .i_req     (r_req),
    .i_mdio    (e_mdio),
    .o_mdc     (e_mdc),
    .o_mdio_o  (w_mdio_o),
    .o_mdio_oe (w_mdio_oe),
    .o_busy    (w_busy),
    .o_rdata   (w_rdata),
    .o_done    (w_done)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= SQ_PWRUP;
      r_cnt    <= '0;
      r_start  <= 1'b0;
      r_req    <= '{op: OP_WR, regad: REG_BMCR, wdata: BMCR_VAL};
      r_status <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_start  <= w_start_nxt;
      r_req    <= w_req_nxt;
      r_status <= w_status_nxt;
    end
  end

  // Sequencer: power-up wait, BMCR write, inter-frame gap, BMSR read(s).
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_start_nxt  = 1'b0;
    w_req_nxt    = r_req;
    w_status_nxt = r_status;

    case (r_state)
      SQ_PWRUP: begin
        if ((r_cnt == CNT_W'(PWRUP_CYC - 1)) && !w_busy) begin
          w_cnt_nxt   = '0;
          w_start_nxt = 1'b1;
          w_req_nxt   = '{op: OP_WR, regad: REG_BMCR, wdata: BMCR_VAL};
          w_state_nxt = SQ_BUSY;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      SQ_BUSY: begin
        if (w_done) begin
          w_status_nxt = w_rdata;
`ifdef MBO53_MDIO_POLL_EN
          w_state_nxt  = SQ_GAP;
`else
          w_state_nxt  = (r_req.op == OP_RD) ? SQ_DONE : SQ_GAP;
`endif
        end
      end
      SQ_GAP: begin
        if ((r_cnt == CNT_W'(GAP_CYC - 1)) && !w_busy) begin
          w_cnt_nxt   = '0;
          w_start_nxt = 1'b1;
          w_req_nxt   = '{op: OP_RD, regad: REG_BMSR, wdata: 16'h0000};
          w_state_nxt = SQ_BUSY;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      SQ_DONE: w_state_nxt = SQ_DONE;
      default: w_state_nxt = SQ_PWRUP;
    endcase
  end

endmodule

// File: tb/tb_mbo_53_top.sv
// Scoreboard bench for mbo_53_top: frames captured on MDC rises are checked against queued expectations.
`timescale 1ns/1ps
module tb_mbo_53_top;

  localparam logic [15:0] PHY_DATA = 16'h782D;
  localparam logic [15:0] BMCR     = 16'h3100;
  localparam logic [4:0]  PHYAD    = 5'h1F;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  regad;
    logic [15:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       BTN_WEST = 1'b0;
  logic [3:0] e_tx_d;
  logic       e_tx_en, e_tx_er;
  logic       e_tx_clk = 1'b0, e_rx_clk = 1'b0;
  logic [3:0] e_rx_d = 4'h0;
  logic       e_rx_er = 1'b0, e_rx_dv = 1'b0, e_crc = 1'b0, e_col = 1'b0;
  logic       e_mdc;
  wire        e_mdio;

  logic phy_oe = 1'b0;
  logic phy_d  = 1'b0;

  // A released bus reads 0, distinguishable from the master's idle data level of 1.
  assign e_mdio = phy_oe ? phy_d : 1'bz;
  pulldown (e_mdio);

  int n_checks = 0;
  int n_fail   = 0;
  int frame_cnt = 0;
  int rst_epoch = 0;
  int seen_epoch = 0;
  int idx = 0;
  bit in_frame = 1'b0;
  logic [63:0] fr = '0;
  frame_t q[$];

  mbo_53_top dut (
    .clk      (clk),
    .BTN_WEST (BTN_WEST),
    .e_tx_d   (e_tx_d),
    .e_tx_en  (e_tx_en),
    .e_tx_er  (e_tx_er),
    .e_tx_clk (e_tx_clk),
    .e_rx_d   (e_rx_d),
    .e_rx_er  (e_rx_er),
    .e_rx_dv  (e_rx_dv),
    .e_rx_clk (e_rx_clk),
    .e_crc    (e_crc),
    .e_col    (e_col),
    .e_mdc    (e_mdc),
    .e_mdio   (e_mdio)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input frame_t f);
    logic [1:0]  ta;
    logic [15:0] d;
    ta = (f.op == 2'b01) ? 2'b10 : 2'b00;
    d  = (f.op == 2'b01) ? f.data : PHY_DATA;
    return {32'hFFFF_FFFF, 2'b01, f.op, PHYAD, f.regad, ta, d};
  endfunction

  // Random activity on the unused receive-side pins.
  initial begin
    forever begin
      @(negedge clk);
      e_rx_d   = 4'($urandom);
      e_rx_dv  = 1'($urandom);
      e_rx_er  = 1'($urandom);
      e_crc    = 1'($urandom);
      e_col    = 1'($urandom);
      e_rx_clk = ~e_rx_clk;
      e_tx_clk = ~e_tx_clk;
    end
  end

  always @(negedge BTN_WEST) rst_epoch++;

  // Bus monitor plus PHY model: drives PHY_DATA during the data phase of reads.
  always begin
    logic   b;
    frame_t e;
    logic [63:0] ex;
    @(posedge e_mdc);
    #1;
    if (seen_epoch != rst_epoch) begin
      seen_epoch = rst_epoch;
      in_frame   = 1'b0;
      idx        = 0;
      phy_oe     = 1'b0;
    end
    b = e_mdio;
    if (!in_frame) begin
      if (b === 1'b1) begin
        in_frame = 1'b1;
        idx      = 1;
        fr       = {63'b0, b};
      end
    end else begin
      fr = {fr[62:0], b};
      idx++;
      if ((idx == 48) && (fr[13:12] == 2'b10)) begin
        phy_oe = 1'b1;
        phy_d  = PHY_DATA[15];
      end else if ((idx > 48) && (idx < 64) && phy_oe) begin
        phy_d = PHY_DATA[63-idx];
      end
      if (idx == 64) begin
        phy_oe   = 1'b0;
        in_frame = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_frame", fr, 64'h0);
        end else begin
          e  = q.pop_front();
          ex = exp_frame(e);
          check((e.op == 2'b01) ? "wr_header" : "rd_header", 64'(fr[63:16]), 64'(ex[63:16]));
          check((e.op == 2'b01) ? "wr_data" : "rd_data", 64'(fr[15:0]), 64'(ex[15:0]));
        end
        frame_cnt++;
      end
    end
  end

  task automatic push_sequence();
    q.delete();
    q.push_back('{op: 2'b01, regad: 5'd0, data: BMCR});
    q.push_back('{op: 2'b10, regad: 5'd1, data: 16'h0000});
  endtask

  task automatic wait_frames(input string tag, input int n);
    for (int i = 0; i < 4000 && frame_cnt < n; i++) @(negedge clk);
    check(tag, 64'(frame_cnt), 64'(n));
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_mdc"}, 64'(e_mdc), 64'd0);
    check({tag, "_mdio_released"}, 64'(e_mdio), 64'd0);
    check({tag, "_tx"}, 64'({e_tx_d, e_tx_en, e_tx_er}), 64'd0);
  endtask

  task automatic measure_mdc_period();
    int   rises = 0;
    int   start_c = 0;
    int   per = 0;
    logic prev;
    prev = e_mdc;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      @(negedge clk);
      if (e_mdc && !prev) begin
        rises++;
        if (rises == 1) start_c = i;
        else per = i - start_c;
      end
      prev = e_mdc;
    end
    check("mdc_period_ns", 64'(per * 20), 64'd400);
  endtask

  initial begin
    int base;
    int fc;
    for (int i = 0; i < 5; i++) begin
      #190;
      check_reset_pins("in_reset");
    end
    check("status_reset", 64'(dut.r_status), 64'h0);
    #50;
    push_sequence();
`ifdef MBO53_MDIO_POLL_EN
    q.push_back('{op: 2'b10, regad: 5'd1, data: 16'h0000});
`endif
    @(negedge clk);
    BTN_WEST = 1'b1;
    measure_mdc_period();
    wait_frames("frame_bmcr_write", 1);
    wait_frames("frame_bmsr_read", 2);
    repeat (20) @(negedge clk);
    check("status_after_read", 64'(dut.r_status), 64'(PHY_DATA));
`ifdef MBO53_MDIO_POLL_EN
    wait_frames("frame_bmsr_poll", 3);
`else
    fc = frame_cnt;
    repeat (3000) @(negedge clk);
    check("no_third_frame", 64'(frame_cnt), 64'(fc));
    check("idle_mdio_released", 64'(e_mdio), 64'd0);
`endif
    check("queue_drained", 64'(q.size()), 64'd0);

    // Reset in the preamble of the second frame, then restart from power-up.
    @(negedge clk);
    BTN_WEST = 1'b0;
    push_sequence();
    #200;
    @(negedge clk);
    BTN_WEST = 1'b1;
    base = frame_cnt;
    wait_frames("restart_write", base + 1);
    for (int i = 0; i < 4000 && !(in_frame && idx >= 8); i++) @(negedge clk);
    check("reach_frame2_preamble", 64'(in_frame && idx >= 8), 64'd1);
    BTN_WEST = 1'b0;
    #1;
    check_reset_pins("mid_frame_reset");
    push_sequence();
    #200;
    @(negedge clk);
    BTN_WEST = 1'b1;
    base = frame_cnt;
    wait_frames("after_abort_write", base + 1);
    wait_frames("after_abort_read", base + 2);
    repeat (20) @(negedge clk);
    check("status_after_abort", 64'(dut.r_status), 64'(PHY_DATA));
    check("tx_idle_end", 64'({e_tx_d, e_tx_en, e_tx_er}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
